// File: rtl/cfg_pwm_timer_if.sv
// cfg_pwm_timer_if: configuration word bundle from the AHB slave
// to the PWM timer (control, period, duty).
interface cfg_pwm_timer_if;
  logic [31:0] cfg_dat0;
  logic [31:0] cfg_dat1;
  logic [31:0] cfg_dat2;

  modport master (
    output cfg_dat0,
    output cfg_dat1,
    output cfg_dat2
  );

  modport slave (
    input cfg_dat0,
    input cfg_dat1,
    input cfg_dat2
  );
endinterface

// File: rtl/cfg_pwm_timer.sv
// cfg_pwm_timer: double-buffered PWM timer with wrap interrupt.
// Optional dead-time complementary output: define CFG_PWM_COMP_EN.
module cfg_pwm_timer #(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  cfg_pwm_timer_if.slave   cfg,
  output logic             pwm_out,
  output logic             pwm_out_n,
  output logic             irq,
  output logic [CNT_W-1:0] cnt_val,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic             en;
  logic             oneshot;
  logic             pol;
  logic             irq_en;
  logic [CNT_W-1:0] per_in;
  logic [CNT_W-1:0] duty_in;

  assign en      = cfg.cfg_dat0[0];
  assign oneshot = cfg.cfg_dat0[1];
  assign pol     = cfg.cfg_dat0[2];
  assign irq_en  = cfg.cfg_dat0[3];
  assign per_in  = cfg.cfg_dat1[CNT_W-1:0];
  assign duty_in = cfg.cfg_dat2[CNT_W-1:0];

  // Fields outside the decoded ranges are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{cfg.cfg_dat0, cfg.cfg_dat1,
                         cfg.cfg_dat2};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ps_q, ps_d;
  logic [CNT_W-1:0] ds_q, ds_d;
  logic             irq_q, irq_d;
  logic             pwm_q, pwm_d;
  logic             load;
  logic             run_d;
  logic             raw_d;

  // Next-state: control FSM, counter and shadow reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    irq_d   = 1'b0;
    load    = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        cnt_d = '0;
        if (en) begin
          state_d = S_RUN;
          load    = 1'b1;
        end
      end
      (state_q == S_RUN): begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == ps_q) begin
          cnt_d = '0;
          load  = 1'b1;
          irq_d = irq_en;
          if (oneshot) state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      (state_q == S_DONE): begin
        cnt_d = '0;
        if (!en) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    ps_d  = load ? per_in  : ps_q;
    ds_d  = load ? duty_in : ds_q;
    run_d = (state_d == S_RUN);
    raw_d = run_d && (cnt_d < ds_d);
  end

`ifdef CFG_PWM_COMP_EN
  logic [7:0] dead_q, dead_d;
  logic [7:0] age_q, age_d;
  logic       lvl_q;
  logic       pwmn_q, pwmn_d;

  // Dead-time: each output waits until raw has held its level
  // for dead cycles, so short pulses vanish and outputs never overlap.
  always_comb begin
    dead_d = load ? cfg.cfg_dat0[15:8] : dead_q;
    age_d  = age_q;
    if (!run_d || state_q != S_RUN || raw_d != lvl_q) begin
      age_d = '0;
    end else if (age_q != 8'hff) begin
      age_d = age_q + 8'd1;
    end
    pwm_d  = (raw_d && age_d >= dead_d) ^ pol;
    pwmn_d = (run_d && !raw_d && age_d >= dead_d) ^ pol;
  end

  // Dead-time state registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dead_q <= '0;
      age_q  <= '0;
      lvl_q  <= 1'b0;
      pwmn_q <= 1'b0;
    end else begin
      dead_q <= dead_d;
      age_q  <= age_d;
      lvl_q  <= raw_d;
      pwmn_q <= pwmn_d;
    end
  end

  assign pwm_out_n = pwmn_q;
`else
  // Without dead-time the output is the raw waveform with polarity.
  always_comb begin
    pwm_d = raw_d ^ pol;
  end

  assign pwm_out_n = 1'b0;
`endif

  // Core state, counter, shadows and registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ps_q    <= '0;
      ds_q    <= '0;
      irq_q   <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      ds_q    <= ds_d;
      irq_q   <= irq_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
  assign irq     = irq_q;
  assign cnt_val = cnt_q;
  assign busy    = (state_q == S_RUN);

endmodule
